// File: rtl/hazard_scoreboard_if.sv
// F/D-D/X hazard bus: instruction registers in, stall/issue control and scoreboard status out.
// Master drives the instruction registers and multdiv ready; slave is the scoreboard.
interface hazard_scoreboard_if #(
   parameter int IW    = 32,
   parameter int RW    = 5,
   parameter int CNT_W = 16
);
   logic [IW-1:0]    fd_ir;
   logic [IW-1:0]    dx_ir;
   logic             md_result_ready;
   logic             select_stall;
   logic             md_start;
   logic             md_busy;
   logic [RW-1:0]    md_dest;
   logic             md_timeout;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output fd_ir, dx_ir, md_result_ready,
      input  select_stall, md_start, md_busy, md_dest, md_timeout, stall_count
   );

   modport slave (
      input  fd_ir, dx_ir, md_result_ready,
      output select_stall, md_start, md_busy, md_dest, md_timeout, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// F/D stall decision plus multdiv scoreboard; stall/start are combinational, status is registered.
// No flow control of its own: select_stall is the backpressure it applies to the F/D stage.
module hazard_scoreboard #(
   parameter int IW         = 32,
   parameter int RW         = 5,
   parameter int MD_TIMEOUT = 40,
   parameter int CNT_W      = 16,
   parameter bit LEGACY_MD  = 1'b0
) (
   input logic                clock,
   input logic                reset,
   hazard_scoreboard_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam int TW = $clog2(MD_TIMEOUT);
   localparam logic [4:0] OP_RTYPE = 5'b00000, OP_BNE  = 5'b00010, OP_JR   = 5'b00100,
                          OP_ADDI  = 5'b00101, OP_BLT  = 5'b00110, OP_SW   = 5'b00111,
                          OP_LW    = 5'b01000, AL_MULT = 5'b00110, AL_DIV  = 5'b00111;

   state_t           state_q, state_d;
   logic [RW-1:0]    md_dest_q, md_dest_d;
   logic             md_timeout_q, md_timeout_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic [4:0]    fd_op, fd_alu, dx_op, dx_alu;
   logic [RW-1:0] fd_rd, fd_rs, fd_rt, dx_rd;
   logic          fd_rtype, fd_is_md, fd_rd_src, fd_writes, dx_is_md, dx_lw;
   logic          hz_load_use, hz_issue, hz_busy, stall, start;
   logic          unused_ir_bits;

   assign fd_op  = bus.fd_ir[IW-1 -: 5];
   assign fd_rd  = bus.fd_ir[IW-6 -: RW];
   assign fd_rs  = bus.fd_ir[IW-11 -: RW];
   assign fd_rt  = bus.fd_ir[IW-16 -: RW];
   assign fd_alu = bus.fd_ir[6:2];
   assign dx_op  = bus.dx_ir[IW-1 -: 5];
   assign dx_rd  = bus.dx_ir[IW-6 -: RW];
   assign dx_alu = bus.dx_ir[6:2];
   assign unused_ir_bits = ^{bus.fd_ir, bus.dx_ir};

   assign fd_rtype  = (fd_op == OP_RTYPE);
   assign fd_is_md  = fd_rtype && (fd_alu == AL_MULT || fd_alu == AL_DIV);
   assign fd_rd_src = (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_JR) || (fd_op == OP_BLT);
   assign fd_writes = fd_rtype || (fd_op == OP_ADDI) || (fd_op == OP_LW);
   assign dx_is_md  = (dx_op == OP_RTYPE) && (dx_alu == AL_MULT || dx_alu == AL_DIV);
   assign dx_lw     = (dx_op == OP_LW);

   // r0 is hard-wired, so it never creates a dependency.
   function automatic logic reads_reg(input logic [RW-1:0] r, rs, rt, rd, input logic use_rt, use_rd);
      return (r != '0) && ((rs == r) || (use_rt && rt == r) || (use_rd && rd == r));
   endfunction

   function automatic logic writes_reg(input logic [RW-1:0] r, rd, input logic wr);
      return (r != '0) && wr && (rd == r);
   endfunction

   always_comb begin
      hz_load_use = dx_lw && reads_reg(dx_rd, fd_rs, fd_rt, fd_rd, fd_rtype, fd_rd_src);
      hz_issue    = dx_is_md && (reads_reg(dx_rd, fd_rs, fd_rt, fd_rd, fd_rtype, fd_rd_src) ||
                                 writes_reg(dx_rd, fd_rd, fd_writes) || fd_is_md);
      hz_busy     = (state_q == BUSY) &&
                    (reads_reg(md_dest_q, fd_rs, fd_rt, fd_rd, fd_rtype, fd_rd_src) ||
                     writes_reg(md_dest_q, fd_rd, fd_writes) || fd_is_md);
      if (LEGACY_MD)
         stall = hz_load_use || (state_q == BUSY) || dx_is_md;
      else
         stall = hz_load_use || hz_issue || hz_busy;
   end

   always_comb begin
      state_d      = state_q;
      md_dest_d    = md_dest_q;
      md_timeout_d = md_timeout_q;
      tmr_d        = tmr_q;
      start        = 1'b0;
      case (state_q)
         IDLE: begin
            if (dx_is_md) begin
               start     = 1'b1;
               state_d   = BUSY;
               md_dest_d = dx_rd;
               tmr_d     = TW'(MD_TIMEOUT - 1);
            end
         end
         BUSY: begin
            // A result arriving on the last timer cycle wins over the timeout.
            if (bus.md_result_ready) begin
               state_d   = IDLE;
               md_dest_d = '0;
            end else if (tmr_q == '0) begin
               state_d      = IDLE;
               md_dest_d    = '0;
               md_timeout_d = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      stall_count_d = stall_count_q;
      if (stall && !(&stall_count_q))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         md_dest_q     <= '0;
         md_timeout_q  <= 1'b0;
         tmr_q         <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         md_dest_q     <= md_dest_d;
         md_timeout_q  <= md_timeout_d;
         tmr_q         <= tmr_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.select_stall = stall;
   assign bus.md_start     = start;
   assign bus.md_busy      = (state_q == BUSY);
   assign bus.md_dest      = md_dest_q;
   assign bus.md_timeout   = md_timeout_q;
   assign bus.stall_count  = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations (default, short timeout/narrow counter, legacy)
// driven with the same directed vectors; expectations are queued per cycle and checked by a monitor.
module tb_hazard_scoreboard;
   localparam int F_STALL = 0, F_START = 1, F_BUSY = 2, F_DEST = 3, F_TMO = 4, F_CNT = 5;

   typedef struct {
      int    cyc;
      int    dut;
      int    fld;
      int    exp;
      string name;
   } exp_t;

   logic clock = 1'b0;
   logic rst_n = 1'b1;
   logic rst_v = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t e;
   int   act;

   hazard_scoreboard_if #(.IW(32), .RW(5), .CNT_W(16)) if0 ();
   hazard_scoreboard_if #(.IW(32), .RW(5), .CNT_W(3))  if1 ();
   hazard_scoreboard_if #(.IW(32), .RW(5), .CNT_W(16)) if2 ();

   hazard_scoreboard #(.IW(32), .RW(5), .MD_TIMEOUT(40), .CNT_W(16), .LEGACY_MD(1'b0))
      d0 (.clock(clock), .reset(rst_n), .bus(if0.slave));
   hazard_scoreboard #(.IW(32), .RW(5), .MD_TIMEOUT(4), .CNT_W(3), .LEGACY_MD(1'b0))
      d1 (.clock(clock), .reset(rst_n), .bus(if1.slave));
   hazard_scoreboard #(.IW(32), .RW(5), .MD_TIMEOUT(4), .CNT_W(16), .LEGACY_MD(1'b1))
      d2 (.clock(clock), .reset(rst_n), .bus(if2.slave));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [31:0] r_ins(input int rd, rs, rt, alu);
      return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
   endfunction

   function automatic logic [31:0] i_ins(input int op, rd, rs);
      return {5'(op), 5'(rd), 5'(rs), 17'd0};
   endfunction

   function automatic int get_out(input int d, input int f);
      int r;
      r = -1;
      case (d)
         0: case (f)
               F_STALL: r = int'(if0.select_stall);
               F_START: r = int'(if0.md_start);
               F_BUSY:  r = int'(if0.md_busy);
               F_DEST:  r = int'(if0.md_dest);
               F_TMO:   r = int'(if0.md_timeout);
               default: r = int'(if0.stall_count);
            endcase
         1: case (f)
               F_STALL: r = int'(if1.select_stall);
               F_START: r = int'(if1.md_start);
               F_BUSY:  r = int'(if1.md_busy);
               F_DEST:  r = int'(if1.md_dest);
               F_TMO:   r = int'(if1.md_timeout);
               default: r = int'(if1.stall_count);
            endcase
         default: case (f)
               F_STALL: r = int'(if2.select_stall);
               F_START: r = int'(if2.md_start);
               F_BUSY:  r = int'(if2.md_busy);
               F_DEST:  r = int'(if2.md_dest);
               F_TMO:   r = int'(if2.md_timeout);
               default: r = int'(if2.stall_count);
            endcase
      endcase
      return r;
   endfunction

   // Monitor: every expectation is bound to the cycle it was issued in.
   always @(negedge clock) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_tests++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: dut%0d check for cycle %0d not sampled (now %0d)", e.name, e.dut, e.cyc, cyc);
         end else begin
            act = get_out(e.dut, e.fld);
            if (act != e.exp) begin
               n_fail++;
               $display("FAIL %s: dut%0d field%0d cycle %0d got %0d expected %0d",
                        e.name, e.dut, e.fld, cyc, act, e.exp);
            end
         end
      end
   end

   task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic rdy);
      @(posedge clock);
      #1;
      rst_n = rst_v;
      if0.fd_ir = fd; if0.dx_ir = dx; if0.md_result_ready = rdy;
      if1.fd_ir = fd; if1.dx_ir = dx; if1.md_result_ready = rdy;
      if2.fd_ir = fd; if2.dx_ir = dx; if2.md_result_ready = rdy;
   endtask

   task automatic chk(input int d, input int f, input int v, input string nm);
      exp_t x;
      x.cyc = cyc; x.dut = d; x.fld = f; x.exp = v; x.name = nm;
      sb.push_back(x);
   endtask

   task automatic do_reset();
      rst_v = 1'b0;
      step(32'd0, 32'd0, 1'b0);
      rst_v = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks pending", sb.size());
      $fatal(1);
   end

   initial begin
      logic [31:0] nop, lw5, lw0, mult4, div9, indep;
      nop   = 32'd0;
      lw5   = i_ins(8, 5, 1);
      lw0   = i_ins(8, 0, 1);
      mult4 = r_ins(4, 2, 3, 6);
      div9  = r_ins(9, 10, 11, 7);
      indep = r_ins(6, 7, 8, 0);
      if0.fd_ir = nop; if0.dx_ir = nop; if0.md_result_ready = 1'b0;
      if1.fd_ir = nop; if1.dx_ir = nop; if1.md_result_ready = 1'b0;
      if2.fd_ir = nop; if2.dx_ir = nop; if2.md_result_ready = 1'b0;

      // Reset state
      do_reset();
      step(nop, nop, 1'b0);
      chk(0, F_BUSY, 0, "rst_busy"); chk(0, F_DEST, 0, "rst_dest"); chk(0, F_TMO, 0, "rst_tmo");
      chk(0, F_CNT, 0, "rst_cnt");   chk(0, F_STALL, 0, "rst_stall"); chk(0, F_START, 0, "rst_start");

      // Load-use
      step(r_ins(1, 5, 2, 0), lw5, 1'b0); chk(0, F_STALL, 1, "lu_rs");
      step(r_ins(1, 2, 3, 0), lw5, 1'b0); chk(0, F_STALL, 0, "lu_indep");
      step(i_ins(8, 5, 6), lw5, 1'b0);    chk(0, F_STALL, 0, "lu_wr_only");
      step(r_ins(1, 0, 0, 0), lw0, 1'b0); chk(0, F_STALL, 0, "lu_r0");
      step(i_ins(7, 5, 1), lw5, 1'b0);    chk(0, F_STALL, 1, "lu_sw_rd");
      step(r_ins(1, 2, 5, 0), lw5, 1'b0); chk(0, F_STALL, 1, "lu_rt");
      step(i_ins(5, 5, 2), lw5, 1'b0);    chk(0, F_STALL, 0, "lu_addi_rd");
      step(nop, nop, 1'b0);               chk(0, F_CNT, 3, "lu_cnt");

      // Multdiv dependency tracking
      do_reset();
      step(nop, mult4, 1'b0);
      chk(0, F_START, 1, "md_issue_start"); chk(0, F_STALL, 0, "md_issue_stall"); chk(0, F_BUSY, 0, "md_issue_busy");
      step(indep, nop, 1'b0);
      chk(0, F_BUSY, 1, "md_busy"); chk(0, F_DEST, 4, "md_dest"); chk(0, F_START, 0, "md_no_restart");
      chk(0, F_STALL, 0, "md_indep");
      step(r_ins(6, 4, 1, 0), nop, 1'b0); chk(0, F_STALL, 1, "md_raw");
      step(i_ins(5, 4, 1), nop, 1'b0);    chk(0, F_STALL, 1, "md_waw");
      step(div9, nop, 1'b0);              chk(0, F_STALL, 1, "md_struct");
      step(r_ins(6, 4, 1, 0), nop, 1'b1); chk(0, F_STALL, 1, "md_rdy_hold"); chk(0, F_BUSY, 1, "md_rdy_busy");
      step(r_ins(6, 4, 1, 0), nop, 1'b0);
      chk(0, F_BUSY, 0, "md_release"); chk(0, F_STALL, 0, "md_release_stall");
      chk(0, F_DEST, 0, "md_release_dest"); chk(0, F_CNT, 4, "md_cnt");
      step(r_ins(5, 3, 0, 0), r_ins(3, 1, 2, 7), 1'b0);
      chk(0, F_STALL, 1, "md_issue_raw"); chk(0, F_START, 1, "md_issue_raw_start");
      step(r_ins(5, 3, 0, 0), nop, 1'b0);
      chk(0, F_BUSY, 1, "md2_busy"); chk(0, F_DEST, 3, "md2_dest"); chk(0, F_STALL, 1, "md2_raw");
      step(r_ins(5, 1, 2, 0), nop, 1'b1); chk(0, F_STALL, 0, "md2_indep_rdy");
      step(nop, nop, 1'b1);               chk(0, F_BUSY, 0, "idle_rdy_ignored");
      step(nop, nop, 1'b0);               chk(0, F_BUSY, 0, "idle_stays"); chk(0, F_TMO, 0, "md_no_tmo");
      step(i_ins(5, 4, 1), mult4, 1'b0);  chk(0, F_STALL, 1, "md_issue_waw");
      step(nop, nop, 1'b1);               chk(0, F_BUSY, 1, "md3_busy");
      step(nop, nop, 1'b0);               chk(0, F_BUSY, 0, "md3_release");

      // Timeout with MD_TIMEOUT=4: ready on the last timer cycle wins
      do_reset();
      step(nop, mult4, 1'b0); chk(1, F_START, 1, "sim_start");
      for (int i = 0; i < 3; i++) begin
         step(nop, nop, 1'b0); chk(1, F_BUSY, 1, "sim_busy");
      end
      step(nop, nop, 1'b1); chk(1, F_BUSY, 1, "sim_busy_last");
      step(nop, nop, 1'b0); chk(1, F_BUSY, 0, "sim_idle"); chk(1, F_TMO, 0, "sim_no_tmo");
      step(nop, mult4, 1'b0); chk(1, F_START, 1, "tmo_start");
      for (int i = 0; i < 4; i++) begin
         step(nop, nop, 1'b0); chk(1, F_BUSY, 1, "tmo_busy");
      end
      step(nop, nop, 1'b0);
      chk(1, F_BUSY, 0, "tmo_release"); chk(1, F_TMO, 1, "tmo_flag"); chk(1, F_DEST, 0, "tmo_dest");
      step(nop, nop, 1'b0);
      step(nop, nop, 1'b0); chk(1, F_TMO, 1, "tmo_sticky");

      // Saturating counter (CNT_W=3)
      for (int i = 0; i < 9; i++) step(r_ins(1, 5, 2, 0), lw5, 1'b0);
      step(nop, nop, 1'b0); chk(1, F_CNT, 7, "cnt_sat"); chk(1, F_TMO, 1, "cnt_tmo_kept");

      // Reset while BUSY
      step(nop, mult4, 1'b0);
      step(nop, nop, 1'b0); chk(1, F_BUSY, 1, "pre_rst_busy"); chk(1, F_DEST, 4, "pre_rst_dest");
      do_reset();
      step(div9, nop, 1'b0);
      chk(1, F_BUSY, 0, "mrst_busy"); chk(1, F_DEST, 0, "mrst_dest"); chk(1, F_TMO, 0, "mrst_tmo");
      chk(1, F_CNT, 0, "mrst_cnt");   chk(1, F_STALL, 0, "mrst_stall"); chk(1, F_START, 0, "mrst_start");

      // Legacy mode versus dependency-aware mode
      do_reset();
      step(indep, mult4, 1'b0);
      chk(2, F_STALL, 1, "leg_issue"); chk(2, F_START, 1, "leg_start"); chk(0, F_STALL, 0, "new_issue");
      for (int i = 0; i < 4; i++) begin
         step(indep, nop, 1'b0); chk(2, F_STALL, 1, "leg_busy_stall"); chk(2, F_BUSY, 1, "leg_busy");
         chk(0, F_STALL, 0, "new_busy_indep");
      end
      step(indep, nop, 1'b0); chk(2, F_BUSY, 0, "leg_release"); chk(2, F_STALL, 0, "leg_idle_stall");
      chk(2, F_CNT, 5, "leg_cnt");
      step(r_ins(1, 5, 2, 0), lw5, 1'b0); chk(2, F_STALL, 1, "leg_lu");

      repeat (3) @(posedge clock);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL pending: %0d checks never sampled, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline stall unit: decides F/D stall from the F/D and D/X instruction registers.
- Adds a registered multdiv scoreboard: tracks the destination register of the in-flight mult/div, runs a timeout counter and sticky timeout flag, and keeps a saturating stall-cycle counter.
- Outside the legacy mode, stalls only dependent, conflicting or structural instructions, not everything while multdiv runs.
- Sits between the F/D and D/X latches and drives latch enables, D/X bubble insertion, and multdiv start.

Parameters:
- IW, 32, instruction width; fields: opcode [IW-1:IW-5], rd [IW-6:IW-10], rs [IW-11:IW-15], rt [IW-16:IW-20], aluop [6:2].
- RW, 5, register-address width (fields above assume 5).
- MD_TIMEOUT, 40, max BUSY cycles before forced release (>=2).
- CNT_W, 16, stall counter width.
- LEGACY_MD, 0, 1 = stall every cycle while BUSY or D/X holds mult/div.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- fd_ir  in  IW  F/D instruction.
- dx_ir  in  IW  D/X instruction.
- md_result_ready  in  1  multdiv result valid this cycle.
- select_stall  out  1  hold PC and F/D, insert D/X nop (combinational).
- md_start  out  1  issue pulse to multdiv (combinational).
- md_busy  out  1  state==BUSY (registered).
- md_dest  out  RW  pending multdiv destination (registered).
- md_timeout  out  1  sticky timeout flag (registered).
- stall_count  out  CNT_W  saturating stall-cycle count (registered).

Behaviour:
- Decode:
  - R-type: opcode 00000.
  - mult: R-type with aluop 00110. div: R-type with aluop 00111. is_md = mult or div.
  - lw: 01000. sw: 00111. addi: 00101.
- F/D source registers:
  - rs always.
  - rt if R-type.
  - rd if opcode is sw, bne (00010), jr (00100) or blt (00110).
- F/D writes rd if opcode is R-type, addi or lw.
- Register 0 never matches any dependency or write check.
- State machine (IDLE, BUSY):
  - IDLE -> BUSY when dx is_md: md_start=1 that cycle; latch md_dest<=dx rd; tmr<=MD_TIMEOUT-1.
  - BUSY -> IDLE on md_result_ready: md_dest<=0.
  - BUSY -> IDLE when tmr==0 without ready: md_timeout<=1, md_dest<=0.
  - Otherwise in BUSY, tmr decrements each cycle.
  - md_start is never asserted in BUSY.
- select_stall, LEGACY_MD=0 — OR of:
  - (a) load-use: dx lw and a F/D source == dx rd.
  - (b) issue cycle: dx is_md and (a F/D source == dx rd, or F/D writes dx rd, or F/D is_md).
  - (c) BUSY and (a F/D source == md_dest, or F/D writes md_dest, or F/D is_md).
- select_stall, LEGACY_MD=1: (a) or md_busy or dx is_md.
- In the cycle md_result_ready arrives, (c) still applies; release is on the next cycle.
- stall_count increments by 1 on each cycle select_stall=1 and holds at all-ones.
- Reset (reset=0 at edge), including mid-operation: state IDLE, md_busy=0, md_dest=0, md_timeout=0, stall_count=0, tmr=0. Combinational outputs then follow the inputs with IDLE state.
- md_result_ready while IDLE is ignored.
- Simultaneous md_result_ready and tmr==0: treated as ready; md_timeout unchanged.

Test Plan:
- Load-use: dx=lw r5; fd=add r1,r5,r2 -> select_stall=1. Same with fd=add r1,r2,r3 -> 0. Same with fd=lw r5,… (writes only, no source match) -> 0.
- Load-use on r0: dx=lw r0; fd=add r1,r0,r0 -> select_stall=0.
- Multdiv dependency: dx=mult r4,r2,r3 -> md_start=1 for one cycle. Next cycle md_busy=1, md_dest=4. During BUSY:
  - fd=add r6,r7,r8 -> stall=0.
  - fd=add r6,r4,r1 -> stall=1.
  - fd=addi r4,… -> stall=1.
  - fd=div -> stall=1.
  - md_result_ready=1 for one cycle -> stall held that cycle; next cycle md_busy=0, stall=0.
- Timeout: MD_TIMEOUT=4, mult issued, no ready -> md_busy high exactly 4 cycles, then IDLE with md_timeout=1. md_timeout stays 1 until reset.
- LEGACY_MD=1: mult issued, fd independent -> stall=1 in the issue cycle and every BUSY cycle.
- Counter and reset: CNT_W=3, force 9 stall cycles -> stall_count=7. Assert reset=0 during BUSY -> next edge all registered outputs are 0.
